// File: rtl/two_ops_accum_if.sv
// ---------------------------------------------------------------------------
// two_ops_accum_if
//   Groups both handshakes of the frame accumulator.
//   Input side : I / I_valid / I_ready  (result stream from the add/sub stage)
//   Output side: O / O_carry / O_valid / O_ready  (framed totals downstream)
//   Modports:
//     slave  - accumulator view (consumes I, produces O)
//     master - environment view (produces I, consumes O)
// ---------------------------------------------------------------------------
interface two_ops_accum_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O;
  logic             O_carry;
  logic             O_valid;
  logic             O_ready;

  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_carry, O_valid
  );

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_carry, O_valid
  );
endinterface

// File: rtl/two_ops_accum.sv
// ---------------------------------------------------------------------------
// two_ops_accum
//   Sums N consecutive accepted samples modulo 2^WIDTH and presents each
//   frame total with a sticky carry-out flag on a registered valid/ready port.
//   Ports:
//     CLK      - clock, rising edge
//     RESET    - synchronous, active-high; clears all state and any frame
//     bus      - two_ops_accum_if.slave
//                I, I_valid -> I_ready  (input stream)
//                O, O_carry, O_valid <- O_ready  (frame output)
//   Parameters:
//     WIDTH    - data width of samples and sum
//     N        - samples per frame, N >= 1
// ---------------------------------------------------------------------------
module two_ops_accum #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic CLK,
  input  logic RESET,
  two_ops_accum_if.slave bus
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_o;
  logic             r_o_carry;
  logic             r_o_valid;

  logic             w_i_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_c;
  logic [WIDTH-1:0] w_s;

  // WIDTH+1-bit add: top bit is the carry-out, low bits wrap modulo 2^WIDTH.
  function automatic logic [WIDTH:0] add_wrap(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Next-state / combinational outputs; I_ready depends only on r_state.
  always_comb begin
    w_state_nxt = r_state;
    w_i_ready   = (r_state == ACC);
    w_accept    = bus.I_valid && w_i_ready;
    {w_c, w_s}  = add_wrap(r_sum, bus.I);
    w_last      = (r_cnt == LAST);
    case (r_state)
      ACC: if (w_accept && w_last) w_state_nxt = OUT;
      OUT: if (bus.O_ready)        w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  // Accumulate / frame-capture stage
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ACC;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_o       <= '0;
      r_o_carry <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_last) begin
          // Last sample: publish the total and restart the frame from zero.
          r_o       <= w_s;
          r_o_carry <= r_carry | w_c;
          r_o_valid <= 1'b1;
          r_sum     <= '0;
          r_carry   <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_sum   <= w_s;
          r_carry <= r_carry | w_c;
          r_cnt   <= r_cnt + CW'(1);
        end
      end
      // In OUT, O_valid is always 1, so O_ready alone completes the handshake.
      if (r_state == OUT && bus.O_ready) r_o_valid <= 1'b0;
    end
  end

  assign bus.I_ready = w_i_ready;
  assign bus.O       = r_o;
  assign bus.O_carry = r_o_carry;
  assign bus.O_valid = r_o_valid;

endmodule

// File: tb/tb_two_ops_accum.sv
// ---------------------------------------------------------------------------
// tb_two_ops_accum
//   Directed bench for two_ops_accum: an N=4 instance and an N=1 instance,
//   with hand-computed expected values checked by immediate assertions.
// ---------------------------------------------------------------------------
module tb_two_ops_accum;

  logic CLK;
  logic RESET;
  int   n_pass;
  int   n_total;

  two_ops_accum_if #(.WIDTH(8)) b4 ();
  two_ops_accum_if #(.WIDTH(8)) b1 ();

  two_ops_accum #(.WIDTH(8), .N(4)) u4 (.CLK(CLK), .RESET(RESET), .bus(b4));
  two_ops_accum #(.WIDTH(8), .N(1)) u1 (.CLK(CLK), .RESET(RESET), .bus(b1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic send4(input logic [7:0] v);
    b4.I       = v;
    b4.I_valid = 1'b1;
    tick();
  endtask

  // Release the completed frame: drop I_valid, handshake for one cycle.
  task automatic drain4(input string tag);
    b4.I_valid = 1'b0;
    b4.O_ready = 1'b1;
    tick();
    chk({tag, "_vld_after_hs"}, b4.O_valid, 0);
    chk({tag, "_rdy_after_hs"}, b4.I_ready, 1);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    RESET      = 1'b1;
    b4.I       = '0;
    b4.I_valid = 1'b0;
    b4.O_ready = 1'b1;
    b1.I       = '0;
    b1.I_valid = 1'b0;
    b1.O_ready = 1'b1;

    // Reset for 2 cycles
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_o_valid", b4.O_valid, 0);
    chk("rst_i_ready", b4.I_ready, 1);
    chk("rst_o",       b4.O, 0);
    chk("rst_o_carry", b4.O_carry, 0);
    chk("rst_n1_o_valid", b1.O_valid, 0);
    chk("rst_n1_i_ready", b1.I_ready, 1);

    // Basic frame 1,2,3,4 -> 10
    send4(8'd1);
    send4(8'd2);
    send4(8'd3);
    chk("basic_no_early_vld", b4.O_valid, 0);
    send4(8'd4);
    chk("basic_o",       b4.O, 10);
    chk("basic_carry",   b4.O_carry, 0);
    chk("basic_vld",     b4.O_valid, 1);
    chk("basic_i_ready", b4.I_ready, 0);
    drain4("basic");

    // Wrap: 4 x 100 = 400 -> 144, carry set
    send4(8'd100);
    send4(8'd100);
    send4(8'd100);
    send4(8'd100);
    chk("wrap_o",     b4.O, 144);
    chk("wrap_carry", b4.O_carry, 1);
    chk("wrap_vld",   b4.O_valid, 1);
    drain4("wrap");

    // Sticky carry cleared: 0,0,0,1 -> 1, no carry
    send4(8'd0);
    send4(8'd0);
    send4(8'd0);
    send4(8'd1);
    chk("clr_o",     b4.O, 1);
    chk("clr_carry", b4.O_carry, 0);
    chk("clr_vld",   b4.O_valid, 1);
    drain4("clr");

    // Back-pressure: frame 3,3,3,3 -> 12 held while O_ready=0 and 7 is offered
    b4.O_ready = 1'b0;
    send4(8'd3);
    send4(8'd3);
    send4(8'd3);
    send4(8'd3);
    b4.I       = 8'd7;
    b4.I_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_o",       b4.O, 12);
      chk("bp_vld",     b4.O_valid, 1);
      chk("bp_i_ready", b4.I_ready, 0);
      if (k < 2) tick();
    end
    b4.O_ready = 1'b1;
    tick();
    chk("bp_hs_vld",   b4.O_valid, 0);
    chk("bp_hs_ready", b4.I_ready, 1);
    send4(8'd7);
    send4(8'd7);
    send4(8'd7);
    chk("bp_no_early_vld", b4.O_valid, 0);
    send4(8'd7);
    chk("bp_o28",   b4.O, 28);
    chk("bp_vld28", b4.O_valid, 1);
    drain4("bp");

    // Bubbles: valid 1,0,1,0,0,1,1 with 5,x,6,x,x,7,8 -> 26
    send4(8'd5);
    b4.I = 8'hAA; b4.I_valid = 1'b0; tick();
    send4(8'd6);
    b4.I = 8'hAA; b4.I_valid = 1'b0; tick();
    b4.I = 8'hAA; b4.I_valid = 1'b0; tick();
    send4(8'd7);
    chk("bub_no_early_vld", b4.O_valid, 0);
    send4(8'd8);
    chk("bub_o",   b4.O, 26);
    chk("bub_vld", b4.O_valid, 1);
    drain4("bub");

    // Reset mid-frame discards 9,9; then 5,5,5,5 -> 20
    send4(8'd9);
    send4(8'd9);
    b4.I_valid = 1'b0;
    RESET      = 1'b1;
    chk("mrst_vld_pre", b4.O_valid, 0);
    tick();
    chk("mrst_vld",   b4.O_valid, 0);
    chk("mrst_ready", b4.I_ready, 1);
    RESET = 1'b0;
    send4(8'd5);
    send4(8'd5);
    chk("mrst_no_early_vld", b4.O_valid, 0);
    send4(8'd5);
    send4(8'd5);
    chk("mrst_o",     b4.O, 20);
    chk("mrst_carry", b4.O_carry, 0);
    chk("mrst_vld20", b4.O_valid, 1);
    drain4("mrst");

    // N=1 build: 0xFF then 0x01, I_ready toggles 1,0,1,0
    chk("n1_ready0", b1.I_ready, 1);
    b1.I       = 8'hFF;
    b1.I_valid = 1'b1;
    tick();
    chk("n1_o_ff",   b1.O, 8'hFF);
    chk("n1_carry1", b1.O_carry, 0);
    chk("n1_vld1",   b1.O_valid, 1);
    chk("n1_ready1", b1.I_ready, 0);
    b1.I = 8'h01;
    tick();
    chk("n1_ready2", b1.I_ready, 1);
    chk("n1_vld_hs", b1.O_valid, 0);
    tick();
    chk("n1_o_01",   b1.O, 8'h01);
    chk("n1_carry2", b1.O_carry, 0);
    chk("n1_vld2",   b1.O_valid, 1);
    chk("n1_ready3", b1.I_ready, 0);
    b1.I_valid = 1'b0;
    tick();
    chk("n1_ready4", b1.I_ready, 1);
    chk("n1_vld_end", b1.O_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/two_ops_accum.md
Name: two_ops_accum

Overview:
- Downstream consumer stage for the 8-bit two-operand add/sub datapath.
- Takes the datapath's result stream over a valid/ready handshake and sums N consecutive results modulo 2^WIDTH.
- Presents each frame sum, plus a sticky carry-out flag, on a registered valid/ready output.
- Converts the purely combinational result stream into framed, back-pressurable totals for the next stage.

Parameters:
- WIDTH, 8, data width of the input results and of the output sum.
- N, 4, number of input samples per frame; legal range N >= 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  result word from the upstream add/sub stage.
- I_valid  input  1  I carries a valid sample this cycle.
- I_ready  output  1  block accepts a sample this cycle.
- O  output  WIDTH  frame sum, modulo 2^WIDTH.
- O_carry  output  1  set if any addition in the frame produced a carry-out of bit WIDTH-1.
- O_valid  output  1  O and O_carry hold a completed frame.
- O_ready  input  1  downstream accepts the frame this cycle.

Behaviour:
- State machine has two states, ACC and OUT.
- Internal registers:
  - sum: WIDTH bits.
  - cnt: clog2(N) bits, minimum 1 bit.
  - carry: 1 bit, sticky.
  - O, O_carry, O_valid: all registered.
- RESET, checked synchronously every cycle with priority over everything else:
  - State returns to ACC.
  - sum, cnt, carry, O, O_carry and O_valid all clear to 0.
  - Any partial frame or pending output frame is discarded.
  - I_ready is 1 in the first cycle after reset is released.
- ACC state:
  - I_ready = 1 and O_valid = 0.
  - A sample is accepted when I_valid && I_ready.
  - On accept, {c, s} = sum + I, computed at WIDTH+1 bits.
  - If cnt < N-1: sum <= s, carry <= carry | c, cnt <= cnt + 1.
  - If cnt == N-1 (last sample of the frame): O <= s, O_carry <= carry | c, O_valid <= 1, then sum, carry and cnt clear to 0, and the state moves to OUT.
  - Cycles where I_valid = 0 are bubbles: no state changes.
- OUT state:
  - I_ready = 0; no sample is accepted even if I_valid = 1.
  - O, O_carry and O_valid hold stable until O_ready = 1.
  - On O_valid && O_ready: O_valid <= 0 and the state moves to ACC.
  - O and O_carry keep their last value after the handshake; they are don't-care while O_valid = 0.
- Latency and throughput:
  - The last sample accepted at cycle t gives O_valid = 1 at cycle t+1.
  - Minimum frame period is N+1 cycles: N accepts plus 1 output cycle, with O_ready tied high.
- Arithmetic:
  - All sums wrap modulo 2^WIDTH.
  - The carry-out of each addition is OR-accumulated into the sticky flag.
  - No saturation.
- N = 1: every accepted sample goes directly to OUT with O = I and O_carry = 0.
- I_ready depends only on the registered state, never combinationally on I_valid or O_ready.
- O_valid never drops without a handshake, except on RESET.
- Upstream may hold I_valid high through OUT; the held sample is accepted in the first ACC cycle.

Test Plan:
- Basic frame: RESET for 2 cycles, N=4, I = 1, 2, 3, 4 on consecutive cycles, O_ready = 1.
  - Required: O = 10, O_carry = 0, O_valid high for exactly 1 cycle, at the cycle after the 4th accept.
  - Required: I_ready = 0 during that cycle.
- Wrap: I = 100, 100, 100, 100.
  - Required: O = 144 (400 mod 256), O_carry = 1.
  - Next frame I = 0, 0, 0, 1 gives O = 1, O_carry = 0, proving the sticky carry clears.
- Back-pressure: hold O_ready = 0 for 3 cycles after a frame completes, with I_valid = 1 and I = 7.
  - Required: O holds stable, O_valid = 1, I_ready = 0 for all 3 cycles.
  - Required: after the handshake, 7 is accepted first and the frame 7, 7, 7, 7 gives O = 28.
- Bubbles: I_valid = 1, 0, 1, 0, 0, 1, 1 carrying 5, x, 6, x, x, 7, 8.
  - Required: O = 26, with O_valid asserted the cycle after the 8 is accepted.
- Reset mid-frame: accept 9, 9, assert RESET for 1 cycle, then send 5, 5, 5, 5.
  - Required: O_valid stays 0 throughout the reset.
  - Required: the next output is O = 20, O_carry = 0.
- N=1 build: I = 0xFF, 0x01.
  - Required: two frames O = 0xFF then O = 0x01, both with O_carry = 0.
  - Required: with O_ready tied high, I_ready toggles 1, 0, 1, 0.
